add4_share_ctrl: RTL and testbench

- Round-robin controller that time-shares one external add4 unit (four 4-bit operands in; 4-bit sum and ov out) among NREQ requesters.
- Flow: sample requests, grant one requester, register its four operands onto the adder inputs, capture sum/ov, return them with a one-cycle done pulse.
- Sits between requester blocks and the single add4 instance at the datapath top level.

---
 rtl/add4_share_pkg.sv | 16 +
 rtl/add4_share_ctrl_rr_pick.sv | 29 ++
 rtl/add4_share_ctrl.sv | 138 +++++++++++++
 tb/tb_add4_share_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/add4_share_pkg.sv
// Shared types and constants for the add4 sharing controller.
package add4_share_pkg;

  localparam int OPND_W  = 4;
  localparam int NOPND   = 4;
  localparam int SLICE_W = OPND_W * NOPND;

  localparam logic [OPND_W-1:0] SAT_VAL = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE
  } state_t;

endpackage

// File: rtl/add4_share_ctrl_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   winner
);

  always_comb begin
    logic found;
    int   idx;
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/add4_share_ctrl.sv
// Time-shares one external add4 unit among NREQ requesters, round-robin.
// Optional macro ADD4_SHARE_SAT_EN saturates res_sum to 4'hF on overflow.
module add4_share_ctrl
  import add4_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*NOPND*W-1:0] opnd,
  output logic [NREQ-1:0]       grant,
  output logic                  done,
  output logic [W-1:0]          res_sum,
  output logic                  res_ov,
  output logic [W-1:0]          add_a,
  output logic [W-1:0]          add_b,
  output logic [W-1:0]          add_c,
  output logic [W-1:0]          add_d,
  input  logic [W-1:0]          add_sum,
  input  logic                  add_ov
);

  localparam int PW = $clog2(NREQ);
  localparam int SW = NOPND * W;

  state_t state_reg, state_next;

  logic [NREQ-1:0] grant_reg;
  logic [PW-1:0]   ptr_reg;
  logic [PW-1:0]   win_reg;
  logic            done_reg;
  logic [W-1:0]    res_sum_reg;
  logic            res_ov_reg;
  logic [W-1:0]    a_reg, b_reg, c_reg, d_reg;

  logic [NREQ-1:0] pick_grant;
  logic [PW-1:0]   pick_idx;
  logic [W-1:0]    sum_cap;
  logic            load_op, capture, finish;

  logic [SW-1:0] slice [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign slice[gi] = opnd[gi*SW +: SW];
    end
  endgenerate

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (ptr_reg),
    .grant  (pick_grant),
    .winner (pick_idx)
  );

`ifdef ADD4_SHARE_SAT_EN
  assign sum_cap = add_ov ? SAT_VAL : add_sum;
`else
  assign sum_cap = add_sum;
`endif

  always_comb begin
    state_next = state_reg;
    load_op    = 1'b0;
    capture    = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          load_op    = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        capture    = 1'b1;
        state_next = CAPTURE;
      end
      CAPTURE: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_reg   <= '0;
      ptr_reg     <= '0;
      win_reg     <= '0;
      done_reg    <= 1'b0;
      res_sum_reg <= '0;
      res_ov_reg  <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      c_reg       <= '0;
      d_reg       <= '0;
    end else begin
      if (load_op) begin
        grant_reg                    <= pick_grant;
        win_reg                      <= pick_idx;
        {d_reg, c_reg, b_reg, a_reg} <= slice[pick_idx];
      end
      if (capture) begin
        res_sum_reg <= sum_cap;
        res_ov_reg  <= add_ov;
        done_reg    <= 1'b1;
      end
      if (finish) begin
        done_reg  <= 1'b0;
        grant_reg <= '0;
        // The served requester drops to lowest priority next round.
        ptr_reg   <= (win_reg == PW'(NREQ - 1)) ? '0 : win_reg + 1'b1;
      end
    end
  end

  assign grant   = grant_reg;
  assign done    = done_reg;
  assign res_sum = res_sum_reg;
  assign res_ov  = res_ov_reg;
  assign add_a   = a_reg;
  assign add_b   = b_reg;
  assign add_c   = c_reg;
  assign add_d   = d_reg;

endmodule

// File: tb/tb_add4_share_ctrl.sv
// Directed, table-driven bench for add4_share_ctrl with a behavioural add4 model.
module tb_add4_share_ctrl;

  localparam int NREQ = 4;
  localparam int W    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*16-1:0] opnd;
  logic [NREQ-1:0]   grant;
  logic              done;
  logic [W-1:0]      res_sum;
  logic              res_ov;
  logic [W-1:0]      add_a, add_b, add_c, add_d;
  logic [W-1:0]      add_sum;
  logic              add_ov;
  logic [5:0]        add_total;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  // Reference add4: wrapped sum, overflow when the true sum exceeds 15.
  assign add_total = 6'(add_a) + 6'(add_b) + 6'(add_c) + 6'(add_d);
  assign add_sum   = add_total[3:0];
  assign add_ov    = (add_total > 6'd15);

  add4_share_ctrl #(.NREQ(NREQ), .W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .opnd    (opnd),
    .grant   (grant),
    .done    (done),
    .res_sum (res_sum),
    .res_ov  (res_ov),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_c   (add_c),
    .add_d   (add_d),
    .add_sum (add_sum),
    .add_ov  (add_ov)
  );

  typedef struct {
    logic [3:0]  req;
    logic [63:0] opnd;
    logic [3:0]  grant;
    logic [3:0]  a;
    logic [3:0]  sum;
    logic [3:0]  sat;
    logic        ov;
  } vec_t;

  // requester slices {d,c,b,a}: r0 sums to 4, r1 to 8, r2 to 13
  localparam logic [47:0] LOW3 = {16'h1543, 16'h2222, 16'h1111};

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_grant(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (grant != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit          ok;
    logic [3:0]  exp_sum;
    int          n, last;
    int          fair_idx [5];
    logic        seen;

    vecs[0] = '{4'b0100, {16'h0000, LOW3}, 4'b0100, 4'd3, 4'd13, 4'd13, 1'b0};
    vecs[1] = '{4'b1001, {16'hFFFF, LOW3}, 4'b1000, 4'hF, 4'd12, 4'd15, 1'b1};
    vecs[2] = '{4'b1001, {16'hFFFF, LOW3}, 4'b0001, 4'd1, 4'd4,  4'd4,  1'b0};
    vecs[3] = '{4'b0011, {16'h0000, LOW3}, 4'b0010, 4'd2, 4'd8,  4'd8,  1'b0};
    vecs[4] = '{4'b0011, {16'h0000, LOW3}, 4'b0001, 4'd1, 4'd4,  4'd4,  1'b0};
    vecs[5] = '{4'b1000, {16'h7654, LOW3}, 4'b1000, 4'd4, 4'd6,  4'd15, 1'b1};
    fair_idx = '{0, 1, 2, 3, 0};

    rst  = 1'b1;
    req  = '0;
    opnd = '0;
    repeat (2) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_sum", res_sum, 0);
    check("rst_ov", res_ov, 0);
    check("rst_ops", {add_d, add_c, add_b, add_a}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Table: pointer carries over from one vector to the next.
    for (int i = 0; i < 6; i++) begin
      req  = vecs[i].req;
      opnd = vecs[i].opnd;
      wait_done(8, ok);
      check($sformatf("v%0d_done_seen", i), ok, 1);
`ifdef ADD4_SHARE_SAT_EN
      exp_sum = vecs[i].sat;
`else
      exp_sum = vecs[i].sum;
`endif
      check($sformatf("v%0d_grant", i), grant, vecs[i].grant);
      check($sformatf("v%0d_add_a", i), add_a, vecs[i].a);
      check($sformatf("v%0d_sum", i), res_sum, exp_sum);
      check($sformatf("v%0d_ov", i), res_ov, vecs[i].ov);
      req = '0;
      @(negedge clk);
      check($sformatf("v%0d_end", i), {grant, 3'b000, done}, 0);
    end

    // Fairness: all requesting, pointer at 0.
    req  = 4'b1111;
    opnd = {16'h0000, LOW3};
    n    = 0;
    last = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(negedge clk);
      if (done) begin
        check($sformatf("fair_grant%0d", n), grant, 4'b0001 << fair_idx[n]);
        if (n > 0) check($sformatf("fair_gap%0d", n), c - last, 3);
        last = c;
        n++;
      end
    end
    check("fair_count", n, 5);
    req = '0;
    @(negedge clk);

    // req dropped in ISSUE; latched operands must still be summed.
    req  = 4'b0010;
    opnd = {16'h0000, LOW3};
    wait_grant(8, ok);
    check("drop_grant_seen", ok, 1);
    req           = '0;
    opnd[31:16]   = 16'hFFFF;
    @(negedge clk);
    check("drop_done", done, 1);
    check("drop_sum", res_sum, 8);
    check("drop_ov", res_ov, 0);
    @(negedge clk);
    check("drop_done_low", done, 0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | (|grant) | done;
    end
    check("drop_idle", seen, 0);

    // Reset during ISSUE; pointer was 2 before the abort.
    req  = 4'b0100;
    opnd = {16'h0000, LOW3};
    wait_grant(8, ok);
    check("rst_issue_seen", ok, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_grant", grant, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_sum", res_sum, 0);
    check("rst_mid_ops", {add_d, add_c, add_b, add_a}, 0);
    req  = '0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | done;
    end
    rst = 1'b0;
    @(negedge clk);
    seen = seen | done;
    check("rst_no_done", seen, 0);

    req = 4'b0110;
    wait_done(8, ok);
    check("post_rst_done_seen", ok, 1);
    check("post_rst_grant", grant, 4'b0010);
    check("post_rst_sum", res_sum, 8);
    req = '0;
    @(negedge clk);
    req = 4'b0001;
    wait_done(8, ok);
    check("post_rst_r0_seen", ok, 1);
    check("post_rst_r0_grant", grant, 4'b0001);
    check("post_rst_r0_sum", res_sum, 4);
    req = '0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
